// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multicycle RISC-V datapath with memory wait states and an illegal-instruction trap.
module multicycle_ctrl #(
   parameter int MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output logic       pcupdate,
   output logic       irwrite,
   output logic       adrsrc,
   output logic       memread,
   output logic       memwrite,
   output logic       regwrite,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] resultsrc,
   output logic       branch,
   output logic [2:0] branch_cond,
   output logic       retire,
   output logic       illegal
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
      EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP
   } state_t;
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       last, waiting, bad_br;
   logic       pcu, irw, rw, mw, ret;
   assign last    = cnt_q == 4'(MEM_WAIT);
   assign waiting = state_q inside {FETCH, MEMREAD, MEMWRITE};
   assign cnt_d   = (waiting && !last) ? cnt_q + 4'd1 : 4'd0;
   assign bad_br  = funct3[2:1] == 2'b01;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   always_comb begin
      state_d   = state_q;
      pcu       = 1'b0;
      irw       = 1'b0;
      rw        = 1'b0;
      mw        = 1'b0;
      ret       = 1'b0;
      adrsrc    = 1'b0;
      memread   = 1'b0;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      resultsrc = 2'b00;
      branch    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         FETCH: begin
            memread   = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            pcu       = last;
            irw       = last;
            state_d   = last ? DECODE : FETCH;
         end
         DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (opcode)
               7'b0000011, 7'b0100011: state_d = MEMADR;
               7'b0110011:             state_d = EXECR;
               7'b0010011:             state_d = EXECI;
               7'b0010111:             state_d = ALUWB;
               7'b0110111:             state_d = LUI;
               7'b1101111:             state_d = JAL;
               7'b1100111:             state_d = JALR;
               7'b1100011:             state_d = BRANCH;
               default:                state_d = TRAP;
            endcase
         end
         MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            state_d = opcode[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc  = 1'b1;
            memread = 1'b1;
            state_d = last ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            resultsrc = 2'b01;
            rw        = 1'b1;
            ret       = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            adrsrc  = 1'b1;
            mw      = 1'b1;
            ret     = last;
            state_d = last ? FETCH : MEMWRITE;
         end
         EXECR: begin
            alusrca = 2'b10;
            aluop   = 2'b10;
            state_d = ALUWB;
         end
         EXECI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = 2'b10;
            state_d = ALUWB;
         end
         LUI: begin
            alusrcb = 2'b01;
            aluop   = 2'b11;
            state_d = ALUWB;
         end
         ALUWB: begin
            rw      = 1'b1;
            ret     = 1'b1;
            state_d = FETCH;
         end
         // funct3 010/011 are not branches: trap without evaluating or retiring
         BRANCH: begin
            alusrca = 2'b10;
            aluop   = 2'b01;
            branch  = !bad_br;
            ret     = !bad_br;
            state_d = bad_br ? TRAP : FETCH;
         end
         JALR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            state_d = JAL;
         end
         JAL: begin
            alusrca = 2'b01;
            alusrcb = 2'b10;
            pcu     = 1'b1;
            state_d = ALUWB;
         end
         TRAP:    illegal = 1'b1;
         default: state_d = FETCH;
      endcase
   end
   assign branch_cond = branch ? funct3 : 3'b000;
   // reset is async, so the architectural enables are gated combinationally to drop at once
   assign pcupdate = pcu & ~reset;
   assign irwrite  = irw & ~reset;
   assign regwrite = rw & ~reset;
   assign memwrite = mw & ~reset;
   assign retire   = ret & ~reset;
endmodule
